// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared state encoding and default timing for the traffic phase controller.
package traffic_pkg;
  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2,
    ST_FLASH  = 2'd3
  } state_t;

  localparam int DEF_N_APPR   = 2;
  localparam int DEF_CNT_W    = 8;
  localparam int DEF_GREEN_T  = 20;
  localparam int DEF_YELLOW_T = 4;
  localparam int DEF_ALLRED_T = 2;
  localparam int DEF_PED_T    = 10;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Control inputs and lamp/status outputs of the traffic phase controller.
interface traffic_phase_ctrl_if
  import traffic_pkg::*;
#(
  parameter int N_APPR = DEF_N_APPR,
  parameter int AW     = (N_APPR > 1) ? $clog2(N_APPR) : 1
);
  logic              tick;
  logic [N_APPR-1:0] ped_req;
  logic              hold;
  logic              night_mode;
  logic [N_APPR-1:0] green;
  logic [N_APPR-1:0] yellow;
  logic [N_APPR-1:0] red;
  logic [N_APPR-1:0] walk;
  logic [AW-1:0]     cur_appr;
  state_t            state;

  modport master (
    output tick, ped_req, hold, night_mode,
    input  green, yellow, red, walk, cur_appr, state
  );
  modport slave (
    input  tick, ped_req, hold, night_mode,
    output green, yellow, red, walk, cur_appr, state
  );
endinterface

// File: rtl/traffic_phase_ctrl_phase_timer.sv
// Tick-driven down-counter: load wins over count, saturates at zero.
module phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             freeze,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              cnt <= RST_VAL;
    else if (load)                          cnt <= load_val;
    else if (tick && !freeze && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/traffic_phase_ctrl.sv
// Round-robin traffic phase controller with latched pedestrian service.
// Optional night flash mode enabled by defining NIGHT_FLASH_EN.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int N_APPR   = DEF_N_APPR,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int GREEN_T  = DEF_GREEN_T,
  parameter int YELLOW_T = DEF_YELLOW_T,
  parameter int ALLRED_T = DEF_ALLRED_T,
  parameter int PED_T    = DEF_PED_T
) (
  input  logic                 clock,
  input  logic                 reset,
  traffic_phase_ctrl_if.slave  bus
);
  localparam int AW        = (N_APPR > 1) ? $clog2(N_APPR) : 1;
  localparam int GREEN_LEN = imax(GREEN_T, PED_T);

  state_t            state_q, state_n;
  logic [AW-1:0]     cur_q, cur_n;
  logic              first_q, first_n;
  logic [N_APPR-1:0] lat_q, lat_n, clr;
  logic [N_APPR-1:0] green_q, yellow_q, red_q, walk_q;
  logic [N_APPR-1:0] green_n, yellow_n, red_n, walk_n, flash_n, oh_n;
  logic              ph_load, ph_zero, ph_freeze, ph_fire, wk_load, wk_zero;
  logic [CNT_W-1:0]  ph_val;

  // hold only stretches green; yellow and all-red always run on tick
  assign ph_freeze = bus.hold && (state_q == ST_GREEN);
  assign ph_fire   = bus.tick && ph_zero && !ph_freeze;

  phase_timer #(.CNT_W(CNT_W), .RST_VAL(CNT_W'(ALLRED_T-1))) u_phase (
    .clock(clock), .reset(reset), .tick(bus.tick), .freeze(ph_freeze),
    .load(ph_load), .load_val(ph_val), .zero(ph_zero)
  );

  phase_timer #(.CNT_W(CNT_W), .RST_VAL('0)) u_walk (
    .clock(clock), .reset(reset), .tick(bus.tick), .freeze(bus.hold),
    .load(wk_load), .load_val(CNT_W'(PED_T-1)), .zero(wk_zero)
  );

`ifndef NIGHT_FLASH_EN
  logic unused_night;
  assign unused_night = bus.night_mode;
`endif

  always_comb begin
    state_n = state_q;
    cur_n   = cur_q;
    first_n = first_q;
    ph_load = 1'b0;
    ph_val  = CNT_W'(ALLRED_T-1);
    wk_load = 1'b0;
    clr     = '0;
    flash_n = yellow_q;
    case (state_q)
      ST_ALLRED: if (ph_fire) begin
`ifdef NIGHT_FLASH_EN
        if (bus.night_mode) begin
          state_n = ST_FLASH;
          flash_n = '1;
        end else begin
`else
        begin
`endif
          state_n = ST_GREEN;
          // cur_appr reads 0 out of reset, yet the first green must still be approach 0
          cur_n   = (first_q || cur_q == AW'(N_APPR-1)) ? '0 : cur_q + AW'(1);
          first_n = 1'b0;
          ph_load = 1'b1;
          if (lat_q[cur_n]) begin
            wk_load    = 1'b1;
            clr[cur_n] = 1'b1;
            ph_val     = CNT_W'(GREEN_LEN-1);
          end else begin
            ph_val     = CNT_W'(GREEN_T-1);
          end
        end
      end
      ST_GREEN: if (ph_fire) begin
        state_n = ST_YELLOW;
        ph_load = 1'b1;
        ph_val  = CNT_W'(YELLOW_T-1);
      end
      ST_YELLOW: if (ph_fire) begin
        state_n = ST_ALLRED;
        ph_load = 1'b1;
      end
      default: begin
`ifdef NIGHT_FLASH_EN
        if (bus.tick) begin
          if (!bus.night_mode) begin
            state_n = ST_ALLRED;
            cur_n   = AW'(N_APPR-1);
            ph_load = 1'b1;
          end else begin
            flash_n = ~yellow_q;
          end
        end
`else
        state_n = ST_ALLRED;
        ph_load = 1'b1;
`endif
      end
    endcase

    oh_n     = N_APPR'(1) << cur_n;
    green_n  = (state_n == ST_GREEN) ? oh_n : '0;
    yellow_n = (state_n == ST_YELLOW) ? oh_n : (state_n == ST_FLASH) ? flash_n : '0;
    red_n    = (state_n == ST_GREEN || state_n == ST_YELLOW) ? ~oh_n :
               (state_n == ST_ALLRED) ? '1 : '0;
    if (state_n != ST_GREEN)                     walk_n = '0;
    else if (wk_load)                            walk_n = oh_n;
    else if (bus.tick && !bus.hold && wk_zero)   walk_n = '0;
    else                                         walk_n = walk_q;

    // a new request in the serving cycle re-arms the latch
    lat_n = (lat_q & ~clr) | bus.ped_req;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_ALLRED;
      cur_q    <= '0;
      first_q  <= 1'b1;
      lat_q    <= '0;
      green_q  <= '0;
      yellow_q <= '0;
      red_q    <= '1;
      walk_q   <= '0;
    end else begin
      state_q  <= state_n;
      cur_q    <= cur_n;
      first_q  <= first_n;
      lat_q    <= lat_n;
      green_q  <= green_n;
      yellow_q <= yellow_n;
      red_q    <= red_n;
      walk_q   <= walk_n;
    end
  end

  assign bus.green    = green_q;
  assign bus.yellow   = yellow_q;
  assign bus.red      = red_q;
  assign bus.walk     = walk_q;
  assign bus.cur_appr = cur_q;
  assign bus.state    = state_q;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: tick-count reference model plus directed literal checks.
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;

  localparam int N = 2, CW = 8, G = 3, Y = 1, A = 1, P = 5;
`ifdef NIGHT_FLASH_EN
  localparam bit NIGHT = 1'b1;
`else
  localparam bit NIGHT = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  int   ntests = 0, nfail = 0;
  bit   chk_en = 1'b0;

  traffic_phase_ctrl_if #(.N_APPR(N)) bus();

  traffic_phase_ctrl #(.N_APPR(N), .CNT_W(CW), .GREEN_T(G), .YELLOW_T(Y),
                       .ALLRED_T(A), .PED_T(P)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: phase, approach, ticks left in phase, walk ticks left, latches.
  int            m_ph, m_app, m_left, m_wl;
  logic [N-1:0]  m_lat, m_fy;
  bit            m_first;

  always @(posedge clock or posedge reset) begin : model
    int ph, app, left, wl;
    logic [N-1:0] lat, fy, clr;
    bit first;
    if (reset) begin
      m_ph <= 2; m_app <= 0; m_left <= A; m_wl <= 0;
      m_lat <= '0; m_fy <= '0; m_first <= 1'b1;
    end else begin
      ph = m_ph; app = m_app; left = m_left; wl = m_wl;
      lat = m_lat; fy = m_fy; first = m_first; clr = '0;
      if (bus.tick) begin
        if (ph == 3) begin
          if (!bus.night_mode) begin ph = 2; left = A; app = N-1; end
          else fy = ~fy;
        end else if (!(ph == 0 && bus.hold)) begin
          left--;
          if (wl > 0) wl--;
          if (left == 0) begin
            if (ph == 0) begin ph = 1; left = Y; wl = 0; end
            else if (ph == 1) begin ph = 2; left = A; end
            else if (NIGHT && bus.night_mode) begin ph = 3; fy = '1; end
            else begin
              app = first ? 0 : (app + 1) % N;
              first = 1'b0;
              ph = 0;
              if (lat[app]) begin wl = P; left = (G > P) ? G : P; clr[app] = 1'b1; end
              else left = G;
            end
          end
        end
      end
      lat = (lat & ~clr) | bus.ped_req;
      m_ph <= ph; m_app <= app; m_left <= left; m_wl <= wl;
      m_lat <= lat; m_fy <= fy; m_first <= first;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clock) begin
    logic [N-1:0] oh, eg, ey, er, ew;
    if (chk_en) begin
      oh = N'(1) << m_app;
      eg = (m_ph == 0) ? oh : '0;
      ey = (m_ph == 1) ? oh : (m_ph == 3) ? m_fy : '0;
      er = (m_ph <= 1) ? ~oh : (m_ph == 2) ? '1 : '0;
      ew = (m_ph == 0 && m_wl > 0) ? oh : '0;
      chk("state",  32'(bus.state),    32'(m_ph));
      chk("cur",    32'(bus.cur_appr), 32'(m_app));
      chk("green",  32'(bus.green),    32'(eg));
      chk("yellow", 32'(bus.yellow),   32'(ey));
      chk("red",    32'(bus.red),      32'(er));
      chk("walk",   32'(bus.walk),     32'(ew));
      chk("walk_not_green", 32'(bus.walk & ~bus.green), 32'd0);
    end
  end

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic tick_once();
    bus.tick = 1'b1; cyc(); bus.tick = 1'b0; cyc();
  endtask

  task automatic wait_entry(input int st, input int app, input bit any_app);
    int n = 0;
    do begin tick_once(); n++; end
    while (!(int'(bus.state) == st && (any_app || int'(bus.cur_appr) == app)) && n < 100);
    chk("wait_entry_timeout", 32'(n < 100), 32'd1);
  endtask

  int exp_st[12] = '{2, 0, 0, 0, 1, 2, 0, 0, 0, 1, 2, 0};
  int exp_ca[12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0};

  initial begin
    int glen, wlen, est;
    reset = 1'b1;
    bus.tick = 1'b0; bus.hold = 1'b0; bus.night_mode = 1'b0; bus.ped_req = '0;
    cyc(); cyc();
    chk_en = 1'b1;
    chk("rst_red", 32'(bus.red), 32'h3);
    chk("rst_state", 32'(bus.state), 32'(ST_ALLRED));
    reset = 1'b0;
    cyc();

    // Basic rotation after reset, pinned against literals.
    chk("seq_model_st0", 32'(m_ph), 32'(exp_st[0]));
    for (int k = 1; k < 12; k++) begin
      tick_once();
      chk("seq_model_st", 32'(m_ph), 32'(exp_st[k]));
      chk("seq_model_ca", 32'(m_app), 32'(exp_ca[k]));
      chk("seq_dut_st", 32'(bus.state), 32'(exp_st[k]));
      chk("seq_dut_ca", 32'(bus.cur_appr), 32'(exp_ca[k]));
    end

    // Pedestrian request for approach 1 during G0.
    bus.ped_req = 2'b10; cyc(); bus.ped_req = '0;
    wait_entry(0, 1, 1'b0);
    glen = 0; wlen = 0;
    while (bus.state == ST_GREEN && glen < 50) begin
      if (bus.walk[1]) wlen++;
      glen++;
      tick_once();
    end
    chk("ped_walk_len", 32'(wlen), 32'(P));
    chk("ped_green_len", 32'(glen), 32'(P));
    chk("ped_latch_clr", 32'(dut.lat_q[1]), 32'd0);

    // hold for 5 ticks mid-G0 stretches green; hold in yellow does nothing.
    wait_entry(0, 0, 1'b0);
    glen = 0;
    while (bus.state == ST_GREEN && glen < 50) begin
      bus.hold = (glen >= 1 && glen < 6);
      tick_once();
      glen++;
    end
    chk("hold_green_len", 32'(glen), 32'(G + 5));
    bus.hold = 1'b1;
    glen = 0;
    while (bus.state == ST_YELLOW && glen < 50) begin tick_once(); glen++; end
    chk("hold_yellow_len", 32'(glen), 32'(Y));
    bus.hold = 1'b0;

    // Reset in the middle of Y1.
    wait_entry(1, 1, 1'b0);
    reset = 1'b1; cyc();
    chk("midrst_red", 32'(bus.red), 32'h3);
    chk("midrst_state", 32'(bus.state), 32'(ST_ALLRED));
    chk("midrst_cur", 32'(bus.cur_appr), 32'd0);
    reset = 1'b0; cyc();

    // ped_req[0] held across the G0-entry clear cycle keeps the latch set.
    bus.ped_req = 2'b01; cyc();
    bus.tick = 1'b1; cyc(); bus.tick = 1'b0; bus.ped_req = '0; cyc();
    chk("pedhold_walk0", 32'(bus.walk[0]), 32'd1);
    chk("pedhold_latch", 32'(dut.lat_q[0]), 32'd1);
    wait_entry(0, 0, 1'b0);
    chk("pedhold_walk0_again", 32'(bus.walk[0]), 32'd1);

    // Night flash request sampled at all-red exit.
    bus.night_mode = 1'b1;
    wait_entry(2, 0, 1'b1);
    tick_once();
    est = NIGHT ? 3 : 0;
    chk("night_enter", 32'(bus.state), 32'(est));
`ifdef NIGHT_FLASH_EN
    chk("flash_yel_on", 32'(bus.yellow), 32'h3);
    tick_once();
    chk("flash_yel_off", 32'(bus.yellow), 32'h0);
    tick_once();
    bus.night_mode = 1'b0;
    tick_once();
    chk("flash_exit_state", 32'(bus.state), 32'(ST_ALLRED));
    chk("flash_exit_cur", 32'(bus.cur_appr), 32'(N-1));
    tick_once();
    chk("flash_then_g0", 32'(bus.state), 32'(ST_GREEN));
    chk("flash_then_g0_cur", 32'(bus.cur_appr), 32'd0);
`endif
    bus.night_mode = 1'b0;

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      bus.tick = ($urandom_range(0, 1) == 1);
      bus.hold = ($urandom_range(0, 4) == 0);
      for (int b = 0; b < N; b++) bus.ped_req[b] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) bus.night_mode = ~bus.night_mode;
      reset = ($urandom_range(0, 699) == 0);
      cyc();
    end
    reset = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
